// File: rtl/ysyx_24100006_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
// Sizes for RV32E / RV32I register files and the per-register counter ceiling.
package ysyx_24100006_scoreboard_pkg;

  localparam int NR_REG_RV32E = 16;
  localparam int REG_AW_RV32E = 4;
  localparam int NR_REG_RV32I = 32;
  localparam int REG_AW_RV32I = 5;

  localparam int CNT_W_DEF = 2;

  function automatic int cnt_max_of(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cnt_max_of(CNT_W_DEF);

  typedef logic [REG_AW_RV32E-1:0] reg_idx_e_t;
  typedef logic [REG_AW_RV32I-1:0] reg_idx_i_t;

endpackage

// File: rtl/ysyx_24100006_sb_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
// Updates at the next clock edge; clr wins over inc/dec; underflow is a combinational flag.
module ysyx_24100006_sb_cnt
  import ysyx_24100006_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic is_zero,
  output logic is_one,
  output logic is_max,
  output logic underflow
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(cnt_max_of(CNT_W));
  localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  assign is_zero   = (cnt_q == '0);
  assign is_one    = (cnt_q == ONE_VAL);
  assign is_max    = (cnt_q == MAX_VAL);
  assign underflow = dec & is_zero;

  // Simultaneous inc and dec cancel; the ends of the range hold rather than wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc & ~dec & ~is_max) begin
      cnt_q <= cnt_q + ONE_VAL;
    end else if (dec & ~inc & ~is_zero) begin
      cnt_q <= cnt_q - ONE_VAL;
    end
  end

endmodule

// File: rtl/ysyx_24100006_scoreboard.sv
// Per-register pending-write scoreboard driving the ID stall (RAW, WAW-full) from counters.
// stall_id is combinational; issue seen by ID next cycle; commit clears a stall same cycle with bypass.
module ysyx_24100006_scoreboard
  import ysyx_24100006_scoreboard_pkg::*;
#(
  parameter int NR_REG    = NR_REG_RV32E,
  parameter int REG_AW    = REG_AW_RV32E,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BYPASS_WB = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic              id_fire,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_ren,
  input  logic              id_rs2_ren,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              wb_fire,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wen,
  input  logic              flush,
  output logic              stall_id,
  output logic              busy,
  output logic              err_underflow
);

  localparam int              NSLOT    = 1 << REG_AW;
  localparam logic [REG_AW:0] NR_REG_W = (REG_AW+1)'(NR_REG);

  // x0 and indices past the register file never hold a count.
  function automatic logic tracked(input logic [REG_AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NR_REG_W);
  endfunction

  logic [NSLOT-1:0] is_zero;
  logic [NSLOT-1:0] is_one;
  logic [NSLOT-1:0] is_max;
  logic [NSLOT-1:0] uf;

  logic issue;
  logic commit;
  logic byp_rs1;
  logic byp_rs2;
  logic haz_rs1;
  logic haz_rs2;
  logic full;
  logic err_q;

  assign commit = wb_fire & wb_wen & tracked(wb_rd);

  // A source whose single outstanding writer retires now reads the write-through value.
  assign byp_rs1 = (BYPASS_WB != 0) & is_one[id_rs1] & commit & (wb_rd == id_rs1);
  assign byp_rs2 = (BYPASS_WB != 0) & is_one[id_rs2] & commit & (wb_rd == id_rs2);

  assign haz_rs1 = id_rs1_ren & tracked(id_rs1) & ~is_zero[id_rs1] & ~byp_rs1;
  assign haz_rs2 = id_rs2_ren & tracked(id_rs2) & ~is_zero[id_rs2] & ~byp_rs2;

  // Full ignores a same-cycle commit so this path never depends on WB.
  assign full = id_wen & tracked(id_rd) & is_max[id_rd];

  assign stall_id = id_valid & (haz_rs1 | haz_rs2 | full) & ~flush;
  assign issue    = id_fire & ~stall_id & id_wen & tracked(id_rd);

  generate
    for (genvar r = 0; r < NSLOT; r++) begin : g_slot
      if (r == 0 || r >= NR_REG) begin : g_none
        assign is_zero[r] = 1'b1;
        assign is_one[r]  = 1'b0;
        assign is_max[r]  = 1'b0;
        assign uf[r]      = 1'b0;
      end else begin : g_cnt
        logic inc_r;
        logic dec_r;

        assign inc_r = issue  & (id_rd == REG_AW'(r));
        assign dec_r = commit & (wb_rd == REG_AW'(r));

        ysyx_24100006_sb_cnt #(
          .CNT_W(CNT_W)
        ) u_cnt (
          .clock    (clock),
          .reset_n  (reset_n),
          .inc      (inc_r),
          .dec      (dec_r),
          .clr      (flush),
          .is_zero  (is_zero[r]),
          .is_one   (is_one[r]),
          .is_max   (is_max[r]),
          .underflow(uf[r])
        );
      end
    end
  endgenerate

  // A commit absorbed by flush is not an accounting error.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (~flush & (|uf)) begin
      err_q <= 1'b1;
    end
  end

  assign busy          = ~(&is_zero);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ysyx_24100006_scoreboard.sv
// Self-checking bench: vector table, directed multi-cycle sequences, randomized traffic vs queue model.
module tb_ysyx_24100006_scoreboard;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       id_valid, id_fire, id_rs1_ren, id_rs2_ren, id_wen;
  logic [3:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       wb_fire, wb_wen, flush;
  logic       stall_id, busy, err_underflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  ysyx_24100006_scoreboard dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_fire      (id_fire),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_ren   (id_rs1_ren),
    .id_rs2_ren   (id_rs2_ren),
    .id_rd        (id_rd),
    .id_wen       (id_wen),
    .wb_fire      (wb_fire),
    .wb_rd        (wb_rd),
    .wb_wen       (wb_wen),
    .flush        (flush),
    .stall_id     (stall_id),
    .busy         (busy),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic v, f, r1, r2, w, wbf, fl;
    logic [3:0] rs1, rs2, rd, wbrd;
    logic e_stall, e_busy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic v, input logic f, input logic [3:0] rs1, input logic r1,
                              input logic [3:0] rs2, input logic r2, input logic [3:0] rd,
                              input logic w, input logic wbf, input logic [3:0] wbrd,
                              input logic fl, input logic es, input logic eb);
    vec_t t;
    t.v = v; t.f = f; t.rs1 = rs1; t.r1 = r1; t.rs2 = rs2; t.r2 = r2;
    t.rd = rd; t.w = w; t.wbf = wbf; t.wbrd = wbrd; t.fl = fl;
    t.e_stall = es; t.e_busy = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [3:0] rs1, input logic r1,
                       input logic [3:0] rs2, input logic r2, input logic [3:0] rd,
                       input logic w, input logic wbf, input logic [3:0] wbrd, input logic fl);
    id_valid = v; id_fire = f; id_rs1 = rs1; id_rs1_ren = r1; id_rs2 = rs2; id_rs2_ren = r2;
    id_rd = rd; id_wen = w; wb_fire = wbf; wb_rd = wbrd; wb_wen = wbf; flush = fl;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: the list of destinations issued and not yet retired.
  int q[$];

  function automatic int pend(input int r);
    int n = 0;
    foreach (q[i]) if (q[i] == r) n++;
    return n;
  endfunction

  function automatic logic m_haz(input logic ren, input int rs, input logic cm, input int wrd);
    if (!ren || rs == 0 || pend(rs) == 0) return 1'b0;
    if (pend(rs) == 1 && cm && wrd == rs) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic v, f, r1, r2, w, wbf, wbw, fl, cm, exp_stall;
    logic [3:0] rs1, rs2, rd, wbrd;
    int idx;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[3]  = mk(1, 1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 1);
    tbl[4]  = mk(1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 3, 1, 1, 3, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1, 0, 0, 0, 3, 1, 0, 0, 1, 3, 0, 0, 1);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);

    reset_n = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    #2;
    check("reset_stall", stall_id, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err_underflow, 1'b0);
    reset_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].rs1, tbl[i].r1, tbl[i].rs2, tbl[i].r2,
            tbl[i].rd, tbl[i].w, tbl[i].wbf, tbl[i].wbrd, tbl[i].fl);
      check($sformatf("vec%0d_stall", i), stall_id, tbl[i].e_stall);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d_err", i), err_underflow, 1'b0);
      next_cycle();
    end

    // WAW throttle on x7.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      check("waw_issue", stall_id, 1'b0);
      next_cycle();
    end
    drive(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    check("waw_full", stall_id, 1'b1);
    check("waw_busy", busy, 1'b1);
    next_cycle();
    drive(1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    check("waw_full_with_commit", stall_id, 1'b1);
    next_cycle();
    drive(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    check("waw_proceed", stall_id, 1'b0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      next_cycle();
    end
    idle();
    check("waw_drained_busy", busy, 1'b0);
    check("waw_no_underflow", err_underflow, 1'b0);

    // Flush absorbing a same-cycle commit.
    drive(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0); next_cycle();
    drive(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0); next_cycle();
    drive(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0); next_cycle();
    drive(1, 0, 2, 1, 0, 0, 0, 0, 1, 4, 1);
    check("flush_masks_stall", stall_id, 1'b1 & 1'b0);
    check("flush_busy_before", busy, 1'b1);
    next_cycle();
    drive(1, 0, 2, 1, 4, 1, 0, 0, 0, 0, 0);
    check("post_flush_stall", stall_id, 1'b0);
    check("post_flush_busy", busy, 1'b0);
    check("post_flush_err", err_underflow, 1'b0);
    next_cycle();

    // Sticky underflow.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    check("uf_not_yet", err_underflow, 1'b0);
    next_cycle();
    idle();
    check("uf_set", err_underflow, 1'b1);
    drive(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1); next_cycle();
    idle();
    check("uf_sticky", err_underflow, 1'b1);
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    #2;
    check("uf_cleared", err_underflow, 1'b0);
    check("uf_reset_busy", busy, 1'b0);
    next_cycle();

    // Randomized traffic against the pending-list model.
    q.delete();
    for (int c = 0; c < 600; c++) begin
      v   = 1'($urandom_range(0, 1));
      f   = v & 1'($urandom_range(0, 1));
      rs1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rs2 = 4'($urandom_range(0, 7));
      r1  = 1'($urandom_range(0, 1));
      r2  = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      w   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      wbf = 1'b0; wbw = 1'b0; wbrd = 4'($urandom_range(0, 15));
      if (q.size() != 0 && $urandom_range(0, 2) != 0) begin
        wbf = 1'b1; wbw = 1'b1;
        idx = $urandom_range(0, q.size() - 1);
        wbrd = 4'(q[idx]);
      end else if ($urandom_range(0, 3) == 0) begin
        wbf = 1'b1;
      end
      id_valid = v; id_fire = f; id_rs1 = rs1; id_rs2 = rs2; id_rs1_ren = r1; id_rs2_ren = r2;
      id_rd = rd; id_wen = w; wb_fire = wbf; wb_rd = wbrd; wb_wen = wbw; flush = fl;
      #2;
      cm = wbf & wbw & (wbrd != 0);
      exp_stall = v & ~fl & (m_haz(r1, int'(rs1), cm, int'(wbrd)) |
                             m_haz(r2, int'(rs2), cm, int'(wbrd)) |
                             (w & (rd != 0) & (pend(int'(rd)) == 3)));
      check("rand_stall", stall_id, exp_stall);
      check("rand_busy", busy, q.size() != 0);
      check("rand_err", err_underflow, 1'b0);
      if (fl) begin
        q.delete();
      end else begin
        if (cm) begin
          for (int j = 0; j < q.size(); j++) begin
            if (q[j] == int'(wbrd)) begin
              q.delete(j);
              break;
            end
          end
        end
        if (f && !exp_stall && w && rd != 0) q.push_back(int'(rd));
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
